// File: rtl/ir_receiver_bus_interface.sv
// IR packet receiver with a small register window on the shared processor bus.
// Measures burst/gap lengths of the demodulated IR input in prescaled ticks,
// decodes start + select + 4 command bursts, and exposes CMD, SEL and status
// flags (valid/overrun/error, write-1-to-clear) as bus-readable registers.
module ir_receiver_bus_interface #(
  parameter int         TICK_CYCLES = 1000,
  parameter logic [7:0] BASE_ADDR   = 8'hA0,
  parameter int         START_MIN   = 150,
  parameter int         SELECT_MIN  = 20,
  parameter int         SELECT_MAX  = 140,
  parameter int         BIT0_MIN    = 10,
  parameter int         BIT1_MIN    = 35,
  parameter int         BIT_MAX     = 80,
  parameter int         GAP_TIMEOUT = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       IR_RX,
  output logic       PACKET_VALID
);

  localparam int             PW           = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]  PRE_LAST     = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]     START_MIN_L  = 8'(START_MIN);
  localparam logic [7:0]     SELECT_MIN_L = 8'(SELECT_MIN);
  localparam logic [7:0]     SELECT_MAX_L = 8'(SELECT_MAX);
  localparam logic [7:0]     BIT0_MIN_L   = 8'(BIT0_MIN);
  localparam logic [7:0]     BIT1_MIN_L   = 8'(BIT1_MIN);
  localparam logic [7:0]     BIT_MAX_L    = 8'(BIT_MAX);
  localparam logic [7:0]     GAP_L        = 8'(GAP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  // Length counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic          ir_sync_p0, ir_sync_p1, ir_sync_p2;
  logic          rise_p3, fall_p3;
  logic          edge_p3;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    len, len_eff;

  state_t        state, state_n;
  logic [2:0]    phase, phase_n;
  logic [7:0]    sel_sh, sel_sh_n;
  logic [3:0]    cmd_sh, cmd_sh_n;
  logic          class_ok, commit, err_set;

  logic [3:0]    cmd_q;
  logic [7:0]    sel_q;
  logic          valid_q, ovr_q, err_q;

  logic [7:0]    addr_off;
  logic          in_range, w1c;
  logic [7:0]    rd_mux, bus_out;
  logic          rd_en;

  // Two-FF synchronizer, one delay stage and registered rise/fall detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_sync_p0 <= 1'b0;
      ir_sync_p1 <= 1'b0;
      ir_sync_p2 <= 1'b0;
      rise_p3    <= 1'b0;
      fall_p3    <= 1'b0;
    end else begin
      ir_sync_p0 <= IR_RX;
      ir_sync_p1 <= ir_sync_p0;
      ir_sync_p2 <= ir_sync_p1;
      rise_p3    <= ir_sync_p1 & ~ir_sync_p2;
      fall_p3    <= ~ir_sync_p1 & ir_sync_p2;
    end
  end

  assign edge_p3 = rise_p3 | fall_p3;
  assign tick    = (presc == PRE_LAST);
  // Length including a tick landing in this very cycle, so an edge sees
  // exactly floor(cycles / TICK_CYCLES).
  assign len_eff = tick ? sat_inc8(len) : len;

  // Tick prescaler and saturating length counter, both restarted by any edge.
  always_ff @(posedge CLK) begin
    if (RESET || edge_p3) begin
      presc <= '0;
      len   <= 8'd0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      len   <= len_eff;
    end
  end

  // FSM state, phase and shadow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      phase  <= 3'd0;
      sel_sh <= 8'd0;
      cmd_sh <= 4'd0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      sel_sh <= sel_sh_n;
      cmd_sh <= cmd_sh_n;
    end
  end

  // Next-state logic: classify each burst by phase, watch gaps for timeout.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    sel_sh_n = sel_sh;
    cmd_sh_n = cmd_sh;
    class_ok = 1'b0;
    commit   = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rise_p3) begin
          phase_n = 3'd0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (fall_p3) begin
          case (phase)
            3'd0: class_ok = (len_eff >= START_MIN_L);
            3'd1: begin
              class_ok = (len_eff >= SELECT_MIN_L) && (len_eff <= SELECT_MAX_L);
              sel_sh_n = len_eff;
            end
            default: begin
              class_ok = (len_eff >= BIT0_MIN_L) && (len_eff <= BIT_MAX_L);
              cmd_sh_n = {cmd_sh[2:0], (len_eff >= BIT1_MIN_L)};
            end
          endcase
          if (!class_ok) begin
            err_set = 1'b1;
            state_n = IDLE;
          end else if (phase == 3'd5) begin
            commit  = 1'b1;
            state_n = IDLE;
          end else begin
            phase_n = phase + 3'd1;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (rise_p3) begin
          state_n = BURST;
        end else if (len >= GAP_L) begin
          err_set = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign addr_off = BUS_ADDR - BASE_ADDR;
  assign in_range = (addr_off < 8'd3);
  assign w1c      = BUS_WE && (addr_off == 8'd1);

  // Result registers and status flags; a set in the same cycle beats a W1C.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cmd_q   <= 4'd0;
      sel_q   <= 8'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (commit) begin
        cmd_q   <= cmd_sh_n;
        sel_q   <= sel_sh;
        valid_q <= 1'b1;
      end else if (w1c && BUS_DATA[0]) begin
        valid_q <= 1'b0;
      end
      if (commit && valid_q) begin
        ovr_q <= 1'b1;
      end else if (w1c && BUS_DATA[1]) begin
        ovr_q <= 1'b0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end else if (w1c && BUS_DATA[2]) begin
        err_q <= 1'b0;
      end
    end
  end

  // Read multiplexer for the three-register window.
  always_comb begin
    rd_mux = 8'd0;
    case (addr_off)
      8'd0:    rd_mux = {4'b0000, cmd_q};
      8'd1:    rd_mux = {5'b00000, err_q, ovr_q, valid_q};
      8'd2:    rd_mux = sel_q;
      default: rd_mux = 8'd0;
    endcase
  end

  // Registered read: capture value and enable, drive the bus one cycle later.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_en   <= 1'b0;
      bus_out <= 8'd0;
    end else begin
      rd_en   <= in_range && !BUS_WE;
      bus_out <= rd_mux;
    end
  end

  assign BUS_DATA     = rd_en ? bus_out : 8'bzzzz_zzzz;
  assign PACKET_VALID = valid_q;

endmodule

// File: tb/tb_ir_receiver_bus_interface.sv
// Directed bench for ir_receiver_bus_interface with TICK_CYCLES=4.
// A register-level model of CMD/SEL/flags supplies expected read values,
// which are queued when a read is issued and compared when data appears.
module tb_ir_receiver_bus_interface;

  localparam int         TICK = 4;
  localparam logic [7:0] BASE = 8'hA0;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       IR_RX;
  logic       PACKET_VALID;
  wire  [7:0] BUS_DATA;
  logic [7:0] tb_data;
  logic       tb_drv;

  assign BUS_DATA = tb_drv ? tb_data : 8'bzzzz_zzzz;

  // Undriven bus floats to all ones so a released bus is observable.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (BUS_DATA[g]);
  end

  always #5 CLK = ~CLK;

  ir_receiver_bus_interface #(.TICK_CYCLES(TICK), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR),
    .BUS_WE(BUS_WE), .IR_RX(IR_RX), .PACKET_VALID(PACKET_VALID)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic [3:0] m_cmd;
  logic [7:0] m_sel;
  logic       m_v, m_o, m_e;

  function automatic logic [7:0] model_reg(input logic [1:0] off);
    case (off)
      2'd0:    return {4'b0000, m_cmd};
      2'd1:    return {5'b00000, m_e, m_o, m_v};
      default: return m_sel;
    endcase
  endfunction

  function automatic logic bitval(input int t);
    return (t >= 35);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_commit(input logic [3:0] cmd, input logic [7:0] sel);
    if (m_v) m_o = 1'b1;
    m_v   = 1'b1;
    m_cmd = cmd;
    m_sel = sel;
  endtask

  task automatic model_reset();
    m_cmd = 4'd0; m_sel = 8'd0; m_v = 1'b0; m_o = 1'b0; m_e = 1'b0;
  endtask

  // Register read: expectation queued now, compared when BUS_DATA is valid.
  task automatic rd(input logic [1:0] off, input string tag);
    logic [7:0] e;
    string      t;
    exp_q.push_back(model_reg(off));
    tag_q.push_back(tag);
    BUS_ADDR = BASE + {6'd0, off};
    BUS_WE   = 1'b0;
    @(negedge CLK);
    BUS_ADDR = 8'h00;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: observed data with empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, BUS_DATA, e);
    end
    @(negedge CLK);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] data);
    BUS_ADDR = BASE + {6'd0, off};
    BUS_WE   = 1'b1;
    tb_data  = data;
    tb_drv   = 1'b1;
    @(negedge CLK);
    BUS_WE   = 1'b0;
    tb_drv   = 1'b0;
    BUS_ADDR = 8'h00;
    if (off == 2'd1) begin
      if (data[0]) m_v = 1'b0;
      if (data[1]) m_o = 1'b0;
      if (data[2]) m_e = 1'b0;
    end
  endtask

  task automatic chk_z(input string tag);
    check(tag, BUS_DATA, 8'hFF);
  endtask

  task automatic hi(input int t);
    IR_RX = 1'b1;
    repeat (t * TICK) @(negedge CLK);
    IR_RX = 1'b0;
  endtask

  task automatic lo(input int t);
    IR_RX = 1'b0;
    repeat (t * TICK) @(negedge CLK);
  endtask

  task automatic settle();
    repeat (8) @(negedge CLK);
  endtask

  // Full packet with 30-tick gaps; race issues a W1C of valid in the commit cycle.
  task automatic pkt(input int st, input int sel, input int b3, input int b2,
                     input int b1, input int b0, input bit race);
    hi(st);  lo(30);
    hi(sel); lo(30);
    hi(b3);  lo(30);
    hi(b2);  lo(30);
    hi(b1);  lo(30);
    hi(b0);
    if (race) begin
      repeat (3) @(negedge CLK);
      wr(2'd1, 8'h01);
    end
    settle();
  endtask

  task automatic chk_pv(input string tag);
    check(tag, {7'd0, PACKET_VALID}, {7'd0, m_v});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; IR_RX = 1'b0; BUS_WE = 1'b0; BUS_ADDR = 8'h00;
    tb_drv = 1'b0; tb_data = 8'h00;
    model_reset();
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    chk_z("reset_busz");
    chk_pv("reset_pv");
    rd(2'd0, "reset_cmd");
    rd(2'd1, "reset_stat");
    rd(2'd2, "reset_sel");

    pkt(160, 50, 40, 12, 40, 40, 1'b0);
    model_commit({bitval(40), bitval(12), bitval(40), bitval(40)}, 8'd50);
    check("nom_cmd_const", model_reg(2'd0), 8'h0B);
    rd(2'd0, "nom_cmd");
    rd(2'd2, "nom_sel");
    rd(2'd1, "nom_stat");
    chk_pv("nom_pv");

    pkt(160, 60, 12, 40, 12, 12, 1'b0);
    model_commit(4'b0100, 8'd60);
    rd(2'd0, "ovr_cmd");
    rd(2'd1, "ovr_stat");
    rd(2'd2, "ovr_sel");

    wr(2'd1, 8'h03);
    @(negedge CLK);
    rd(2'd1, "clr_stat");
    chk_pv("clr_pv");
    wr(2'd0, 8'hFF);
    wr(2'd2, 8'h00);
    rd(2'd0, "ro_cmd");
    rd(2'd2, "ro_sel");

    hi(160); lo(30); hi(150); settle();
    m_e = 1'b1;
    rd(2'd1, "badsel_stat");
    rd(2'd0, "badsel_cmd");
    wr(2'd1, 8'h04);

    hi(160); lo(30); hi(50); lo(30); hi(5); settle();
    m_e = 1'b1;
    rd(2'd1, "shortbit_stat");
    wr(2'd1, 8'h04);

    hi(100); settle();
    m_e = 1'b1;
    rd(2'd1, "shortstart_stat");
    wr(2'd1, 8'h04);
    rd(2'd1, "err_clr_stat");

    hi(160); lo(110); settle();
    m_e = 1'b1;
    rd(2'd1, "timeout_stat");
    wr(2'd1, 8'h04);
    pkt(160, 50, 40, 12, 40, 40, 1'b0);
    model_commit(4'b1011, 8'd50);
    rd(2'd0, "post_to_cmd");
    rd(2'd1, "post_to_stat");

    wr(2'd1, 8'h01);
    pkt(160, 100, 40, 40, 12, 40, 1'b1);
    model_commit(4'b1101, 8'd100);
    rd(2'd1, "race_stat");
    rd(2'd0, "race_cmd");
    chk_pv("race_pv");

    BUS_ADDR = BASE; BUS_WE = 1'b1;
    repeat (2) @(negedge CLK);
    chk_z("we_busz");
    BUS_WE = 1'b0; BUS_ADDR = BASE + 8'd3;
    repeat (2) @(negedge CLK);
    chk_z("oor_busz");
    BUS_ADDR = BASE - 8'd1;
    repeat (2) @(negedge CLK);
    chk_z("below_busz");
    BUS_ADDR = 8'h00;
    rd(2'd0, "contend_cmd");

    hi(160); lo(30); hi(50); lo(30); hi(40); lo(30);
    IR_RX = 1'b1;
    repeat (5 * TICK) @(negedge CLK);
    RESET = 1'b1;
    IR_RX = 1'b0;
    repeat (6) @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    repeat (4) @(negedge CLK);
    chk_z("rst_busz");
    chk_pv("rst_pv");
    rd(2'd0, "rst_cmd");
    rd(2'd1, "rst_stat");
    rd(2'd2, "rst_sel");
    chk_z("rst_idle_busz");

    pkt(160, 70, 40, 12, 40, 40, 1'b0);
    model_commit(4'b1011, 8'd70);
    rd(2'd0, "post_rst_cmd");
    rd(2'd1, "post_rst_stat");
    rd(2'd2, "post_rst_sel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_receiver_bus_interface.md
# ir_receiver_bus_interface

Bus-addressed IR packet receiver, the receive counterpart of the IR transmitter peripheral. Samples a demodulated IR input (high = carrier burst present), measures burst and gap lengths in prescaled ticks, and decodes one packet of a start burst, a car-select burst and 4 command bursts. The decoded command, the select-burst length and status flags are exposed as read registers on the shared processor bus, with a write-to-clear status register.

## Interface
- TICK_CYCLES, 1000: CLK cycles per measurement tick (10 µs at 100 MHz).
- BASE_ADDR, 8'hA0: bus address of register 0. Registers occupy BASE_ADDR..BASE_ADDR+2.
- START_MIN, 150: minimum start-burst length, in ticks.
- SELECT_MIN, 20 / SELECT_MAX, 140: inclusive window for the select-burst length, in ticks.
- BIT0_MIN, 10: minimum burst length for a valid command bit, in ticks.
- BIT1_MIN, 35: a bit burst of at least this many ticks decodes as 1.
- BIT_MAX, 80: a bit burst longer than this is invalid.
- GAP_TIMEOUT, 100: maximum gap length inside a packet, in ticks.
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high.
- BUS_DATA  inout  8  shared data bus. Driven only while the read enable is set, otherwise Z.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write strobe.
- IR_RX  in  1  demodulated IR input. Asynchronous, high during a burst.
- PACKET_VALID  out  1  copy of status.valid.

## Operation
- Input conditioning:
  - IR_RX passes through a 2-FF synchronizer.
  - Rise and fall are detected on the synchronized signal.
- Tick prescaler:
  - The prescaler counts 0..TICK_CYCLES-1 and emits a 1-cycle tick when it wraps.
  - The prescaler restarts at 0 on every detected edge.
- Length counter:
  - 8 bits, saturating at 255. It increments on each tick and clears on every edge.
- Phase counter: 0 = start, 1 = select, 2..5 = command bits 3..0 (MSB first).
- FSM states: IDLE, BURST, GAP.
  - IDLE: a rise sets phase=0, clears the counters and moves to BURST. Falls are ignored.
  - BURST, on fall, classify the measured length L by phase. If the class is valid and phase<5: phase++ and move to GAP. If phase=5: commit the packet and move to IDLE. If the class is invalid: set the error flag and move to IDLE.
    - Phase 0: valid if L ≥ START_MIN.
    - Phase 1: valid if SELECT_MIN ≤ L ≤ SELECT_MAX. L is stored in sel_shadow.
    - Phases 2..5: valid if BIT0_MIN ≤ L ≤ BIT_MAX. The bit value is (L ≥ BIT1_MIN) and is shifted into cmd_shadow.
  - GAP:
    - A rise clears the counters and moves to BURST.
    - If the length counter reaches GAP_TIMEOUT, set error and move to IDLE.
- Commit:
  - cmd_shadow → CMD register and sel_shadow → SEL register.
  - valid is set. If valid was already 1, overrun is also set and CMD/SEL are overwritten.
- Register map (reads):
  - BASE+0 = {4'b0, CMD[3:0]}.
  - BASE+1 = {5'b0, error, overrun, valid}.
  - BASE+2 = SEL[7:0].
  - Any other address: no drive.
- Writes:
  - A write to BASE+1 clears every flag whose data bit is 1 (W1C).
  - Writes to BASE+0 and BASE+2 are ignored.
- Simultaneous commit or error with a W1C in the same cycle: the set wins.

## Timing
- Reset values:
  - State IDLE; phase, counters, CMD, SEL and shadows all 0.
  - All flags 0 and PACKET_VALID=0.
  - Read enable 0, so BUS_DATA is Z.
- RESET mid-packet aborts immediately. The next packet requires a fresh rise seen from IDLE.
- Read handshake:
  - Cycle N: BUS_ADDR in range with BUS_WE=0. The register value is captured into a bus_out register and the read enable is registered.
  - Cycle N+1: BUS_DATA carries the value from cycle N.
  - The enable drops the cycle after the address leaves the range or BUS_WE rises.
- Write: sampled at the CLK edge where BUS_WE=1. The effect is visible in the flags on the next cycle.
- Edge latency: an IR_RX edge is acted on by the FSM 3 cycles after it (2 synchronizer cycles + edge register).
- Commit latency: flags and CMD update on the cycle after the FSM handles the final fall. PACKET_VALID follows the same cycle.
- Length quantization: L = floor(burst cycles / TICK_CYCLES). This is exact apart from the fixed synchronizer skew, which cancels between edges.
- Bursts longer than 255 ticks saturate at 255. A start burst of 255 is still valid.

## Test plan
All cases use TICK_CYCLES=4 and default windows, and drive IR_RX in multiples of 4 cycles.
- Nominal packet: start 160, gap 30, select 50, gaps 30, bits 40/12/40/40 (1011) → 2 cycles after the final fall, BASE+0 reads 8'h0B, BASE+2 reads 8'd50, BASE+1 reads 8'h01 and PACKET_VALID=1.
- Overrun and clear:
  - A second valid packet 0100 before any clear → BASE+0=8'h04 and BASE+1=8'h03.
  - Write 8'h03 to BASE+1 → BASE+1 reads 8'h00 and PACKET_VALID=0.
- Invalid bursts:
  - A select burst of 150 ticks → BASE+1=8'h04, CMD unchanged.
  - A bit burst of 5 ticks → error set.
  - A start burst of 100 → error set.
- Gap timeout: after a valid start, hold IR_RX low 110 ticks → error set, FSM in IDLE. A following nominal packet then decodes correctly.
- Reset mid-packet: assert RESET during bit 2 → all registers read 0 and BUS_DATA is Z while idle. A following full packet decodes correctly.
- Bus contention and race:
  - With BUS_WE=1 or an out-of-range address, BUS_DATA is never driven.
  - A W1C of bit0 in the exact commit cycle → valid remains 1.
